// File: rtl/div_32_pkg.sv
// Shared definitions for the iterative 32-bit divider: widths, FSM states
// and the two's-complement helper used for operand and result signs.
package div_32_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Conditional two's-complement negation. Applied to -2^31 it returns
    // 2^31, which is the correct unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] cond_neg(
        input logic [DIV_WIDTH-1:0] value,
        input logic                 negate
    );
        return negate ? (~value + DIV_WIDTH'(1)) : value;
    endfunction

endpackage

// File: rtl/div_32_add.sv
// 32-bit adder with carry in/out and signed overflow; the divider drives it
// with b = ~divisor and carry_in = 1 to form rem - divisor.
module add_32
    import div_32_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] a,
    input  logic [DIV_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [DIV_WIDTH-1:0] sum,
    output logic                 carry_out,
    output logic                 overflow
);

    logic [DIV_WIDTH:0] full_sum;

    assign full_sum  = {1'b0, a} + {1'b0, b} + {{DIV_WIDTH{1'b0}}, carry_in};
    assign sum       = full_sum[DIV_WIDTH-1:0];
    assign carry_out = full_sum[DIV_WIDTH];
    assign overflow  = (a[DIV_WIDTH-1] == b[DIV_WIDTH-1]) &&
                       (sum[DIV_WIDTH-1] != a[DIV_WIDTH-1]);

endmodule

// File: rtl/div_32.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: 32 iterations on operand
// magnitudes, then a sign fix-up cycle; quotient is LO, remainder is HI.
module div_32
    import div_32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_quo;
    logic             neg_rem;
    logic             zero_div;

    logic             accept;
    logic             divisor_zero;
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] trial;
    logic             no_borrow;
    logic             quo_bit;

    assign accept       = start && ((state == S_IDLE) || (state == S_DONE));
    assign divisor_zero = (divisor == '0);
    assign dividend_neg = is_signed && dividend[WIDTH-1];
    assign divisor_neg  = is_signed && divisor[WIDTH-1];

    assign rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};

    add_32 u_trial_sub (
        .a         (rem_shift),
        .b         (~dvsr),
        .carry_in  (1'b1),
        .sum       (trial),
        .carry_out (no_borrow),
        .overflow  ()
    );

    // A bit shifted out of rem means the true partial remainder is >= 2^32,
    // which exceeds any divisor; the wrapped trial difference is still exact.
    assign quo_bit = no_borrow || rem[WIDTH-1];

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state is defaulted to the current state before the case so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = divisor_zero ? S_FIX : S_CALC;
            end
            S_CALC: begin
                if (count == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
            end
            S_FIX: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) state_nxt = divisor_zero ? S_FIX : S_CALC;
                else       state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Working registers. On a zero divisor quo holds the raw dividend so it
    // can be returned unmodified as the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            zero_div <= 1'b0;
        end else if (accept) begin
            count    <= '0;
            rem      <= '0;
            quo      <= divisor_zero ? dividend : cond_neg(dividend, dividend_neg);
            dvsr     <= cond_neg(divisor, divisor_neg);
            neg_quo  <= dividend_neg ^ divisor_neg;
            neg_rem  <= dividend_neg;
            zero_div <= divisor_zero;
        end else if (state == S_CALC) begin
            count <= count + CNT_W'(1);
            rem   <= quo_bit ? trial : rem_shift;
            quo   <= {quo[WIDTH-2:0], quo_bit};
        end
    end

    // Result registers change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == S_FIX) begin
            if (zero_div) begin
                quotient    <= '1;
                remainder   <= quo;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= cond_neg(quo, neg_quo);
                remainder   <= cond_neg(rem, neg_rem);
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
